// File: rtl/video_scandoubler.sv
// Line-doubling scan converter: buffers each input line into one of two ping-pong banks and
// replays the previous line twice at ce_out rate. Optional macro SCANLINES_EN blanks the colour
// of the second pass when the scanlines input is high.
module video_scandoubler #(
  parameter int unsigned AW       = 9,
  parameter int unsigned HS_START = 172,
  parameter int unsigned HS_WIDTH = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ce_in,
  input  logic ce_out,
  input  logic r_in,
  input  logic g_in,
  input  logic b_in,
  input  logic i_in,
  input  logic blank_in,
  input  logic hsync_in,
  input  logic vsync_in,
`ifdef SCANLINES_EN
  input  logic scanlines,
`endif
  output logic r,
  output logic g,
  output logic b,
  output logic i,
  output logic blank,
  output logic hsync,
  output logic vsync
);

  localparam int unsigned LineMax = 2 ** AW;

  typedef logic [AW-1:0] addr_t;
  localparam addr_t AddrMax = addr_t'(LineMax - 1);

  typedef enum logic [1:0] {StPass0, StPass1, StDone} rd_state_e;

  // Entry layout: {blank, r, g, b, i}
  logic [4:0] mem_q [0:2*LineMax-1];

  // Write side
  logic  hs_prev_q, hs_prev_d;
  logic  wbank_q, wbank_d;
  logic  vs_line_q, vs_line_d;
  logic  start_pending_q, start_pending_d;
  logic  armed_q, armed_d;
  addr_t waddr_q, waddr_d;
  addr_t len_q, len_d;

  logic       hs_edge;
  logic       wr_bank;
  addr_t      wr_addr;
  logic [4:0] pixel_in;

  // Read side
  rd_state_e  state_q, state_d;
  addr_t      raddr_q, raddr_d;
  addr_t      len_m1;
  logic [4:0] rd_pix;
  logic       hs_win;

  // Output stage
  logic [3:0] rgbi_q, rgbi_d;
  logic       blank_q, blank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  assign pixel_in = {blank_in, r_in, g_in, b_in, i_in};
  assign hs_edge  = ce_in & hsync_in & ~hs_prev_q;

  always_comb begin
    wr_bank = wbank_q;
    wr_addr = waddr_q;
    if (hs_edge) begin
      wr_bank = ~wbank_q;
      wr_addr = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (ce_in) begin
      mem_q[{wr_bank, wr_addr}] <= pixel_in;
    end
  end

  always_comb begin
    hs_prev_d       = hs_prev_q;
    wbank_d         = wbank_q;
    vs_line_d       = vs_line_q;
    start_pending_d = start_pending_q;
    armed_d         = armed_q;
    waddr_d         = waddr_q;
    len_d           = len_q;
    if (ce_out) begin
      start_pending_d = 1'b0;
    end
    if (ce_in) begin
      hs_prev_d = hsync_in;
      if (hs_edge) begin
        len_d     = waddr_q;
        wbank_d   = ~wbank_q;
        waddr_d   = addr_t'(1);
        vs_line_d = vsync_in;
        armed_d   = 1'b1;
        // The first edge after reset only closes a partial line; it is never replayed.
        if (armed_q) begin
          start_pending_d = 1'b1;
        end
      end else if (waddr_q != AddrMax) begin
        waddr_d = waddr_q + addr_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q       <= 1'b0;
      wbank_q         <= 1'b0;
      vs_line_q       <= 1'b0;
      start_pending_q <= 1'b0;
      armed_q         <= 1'b0;
      waddr_q         <= '0;
      len_q           <= '0;
    end else begin
      hs_prev_q       <= hs_prev_d;
      wbank_q         <= wbank_d;
      vs_line_q       <= vs_line_d;
      start_pending_q <= start_pending_d;
      armed_q         <= armed_d;
      waddr_q         <= waddr_d;
      len_q           <= len_d;
    end
  end

  assign len_m1 = len_q - addr_t'(1);

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    if (ce_out) begin
      if (start_pending_q) begin
        raddr_d = '0;
        state_d = (len_q == '0) ? StDone : StPass0;
      end else begin
        case (state_q)
          StPass0: begin
            if (raddr_q == len_m1) begin
              raddr_d = '0;
              state_d = StPass1;
            end else begin
              raddr_d = raddr_q + addr_t'(1);
            end
          end
          StPass1: begin
            if (raddr_q == len_m1) begin
              state_d = StDone;
            end else begin
              raddr_d = raddr_q + addr_t'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_pix = mem_q[{~wbank_q, raddr_q}];
  assign hs_win = (32'(raddr_q) >= HS_START) && (32'(raddr_q) < HS_START + HS_WIDTH);

  // Output registers sample the current address/state, giving one ce_out tick of latency.
  always_comb begin
    blank_d = 1'b1;
    rgbi_d  = 4'b0000;
    hsync_d = 1'b0;
    vsync_d = vsync_q;
    if (state_q != StDone) begin
      {blank_d, rgbi_d} = rd_pix;
      hsync_d           = hs_win;
`ifdef SCANLINES_EN
      if (scanlines && (state_q == StPass1)) begin
        rgbi_d = 4'b0000;
      end
`endif
    end
    if (start_pending_q && (len_q != '0)) begin
      vsync_d = vs_line_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StDone;
      raddr_q <= '0;
      rgbi_q  <= 4'b0000;
      blank_q <= 1'b1;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      if (ce_out) begin
        rgbi_q  <= rgbi_d;
        blank_q <= blank_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
      end
    end
  end

  assign {r, g, b, i} = rgbi_q;
  assign blank        = blank_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;

endmodule

// File: tb/tb_video_scandoubler.sv
// Directed bench for video_scandoubler: a line generator feeds scheduled line lengths and captures
// every ce_out output sample; per-scenario tasks compare captured samples with expected pixels.
module tb_video_scandoubler;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ce_in = 1'b0;
  logic ce_out = 1'b0;
  logic r_in = 1'b0, g_in = 1'b0, b_in = 1'b0, i_in = 1'b0;
  logic blank_in = 1'b1, hsync_in = 1'b0, vsync_in = 1'b0;
  logic r, g, b, i, blank, hsync, vsync;
`ifdef SCANLINES_EN
  logic scanlines = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Line schedule and generator state
  int len_plan [0:63];
  logic vs_plan [0:63];
  int edge_tick [0:63];
  int line_no = -1;
  int pix = 0;
  int cur_len = 0;
  int phase = 3;
  int tick = 0;
  // Captured outputs per ce_out tick: {blank, r, g, b, i, hsync, vsync}
  logic [6:0] cap [0:32767];

  video_scandoubler dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ce_in    (ce_in),
    .ce_out   (ce_out),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .i_in     (i_in),
    .blank_in (blank_in),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
`ifdef SCANLINES_EN
    .scanlines(scanlines),
`endif
    .r        (r),
    .g        (g),
    .b        (b),
    .i        (i),
    .blank    (blank),
    .hsync    (hsync),
    .vsync    (vsync)
  );

  initial forever #5 clock = ~clock;

  // ce_in every 4 clocks, ce_out every 2 clocks (coincident with ce_in on phase 0).
  initial begin
    forever begin
      @(negedge clock);
      if (ce_out) begin
        if (tick < 32768) cap[tick] = {blank, r, g, b, i, hsync, vsync};
        tick++;
      end
      phase  = (phase + 1) % 4;
      ce_in  = (phase == 0);
      ce_out = (phase % 2 == 0);
      if (ce_in) begin
        pix++;
        if (pix >= cur_len) begin
          pix = 0;
          line_no++;
          cur_len = len_plan[line_no];
          edge_tick[line_no] = tick;
        end
        hsync_in = (pix < 4);
        {r_in, g_in, b_in, i_in} = pix[3:0];
        blank_in = (pix >= 440);
        vsync_in = vs_plan[line_no];
      end
    end
  end

  function automatic logic [4:0] exp_pix(input int j);
    logic [3:0] c;
    c = j[3:0];
    return {(j >= 440), c};
  endfunction

  task automatic wait_line(input int n);
    int budget = 40000;
    while (line_no < n && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (line_no < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_line: reached line %0d, required %0d", line_no, n);
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({r, g, b, i, hsync, vsync, blank} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_values: got %b, required %b", {r, g, b, i, hsync, vsync, blank},
               7'b0000001);
    end
    while (!(line_no == 0 && pix >= 20)) @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    n_checks++;
    if ({r, g, b, i, hsync, vsync, blank} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL post_release_idle: got %b, required %b", {r, g, b, i, hsync, vsync, blank},
               7'b0000001);
    end
  endtask

  task automatic test_line_repeat();
    wait_line(4);
    n_checks++;
    if (cap[edge_tick[2] + 1] !== 7'b1000000) begin
      n_fail++;
      $display("FAIL first_start_done: got %b, required %b", cap[edge_tick[2] + 1], 7'b1000000);
    end
    for (int m = 2; m <= 3; m++) begin
      int te;
      te = edge_tick[m];
      for (int j = 0; j < 448; j++) begin
        n_checks++;
        if (cap[te + 2 + j][6:2] !== exp_pix(j)) begin
          n_fail++;
          $display("FAIL repeat_pass0 line %0d pos %0d: got %b, required %b", m, j,
                   cap[te + 2 + j][6:2], exp_pix(j));
        end
        n_checks++;
        if (cap[te + 450 + j][6:2] !== exp_pix(j)) begin
          n_fail++;
          $display("FAIL repeat_pass1 line %0d pos %0d: got %b, required %b", m, j,
                   cap[te + 450 + j][6:2], exp_pix(j));
        end
      end
    end
  endtask

  task automatic test_hsync();
    int te;
    int highs;
    int first;
    logic exp;
    te = edge_tick[3];
    highs = 0;
    first = -1;
    for (int k = 0; k < 896; k++) begin
      exp = ((k % 448) >= 172) && ((k % 448) < 188);
      n_checks++;
      if (cap[te + 2 + k][1] !== exp) begin
        n_fail++;
        $display("FAIL hsync pos %0d: got %b, required %b", k, cap[te + 2 + k][1], exp);
      end
      if (cap[te + 2 + k][1] === 1'b1) highs++;
    end
    for (int t = 1; t < 400; t++) begin
      if (first < 0 && cap[te + t][1] === 1'b1) first = t - 1;
    end
    n_checks++;
    if (highs !== 32) begin
      n_fail++;
      $display("FAIL hsync_count: got %0d, required %0d", highs, 32);
    end
    n_checks++;
    if (first !== 173) begin
      n_fail++;
      $display("FAIL hsync_first_offset: got %0d, required %0d", first, 173);
    end
  endtask

  task automatic test_len_switch();
    int te;
    wait_line(7);
    te = edge_tick[6];
    // The 448-pixel replay finished early, so the start tick shows the idle state.
    n_checks++;
    if (cap[te + 1] !== 7'b1000000) begin
      n_fail++;
      $display("FAIL switch_gap: got %b, required %b", cap[te + 1], 7'b1000000);
    end
    for (int j = 0; j < 456; j++) begin
      n_checks++;
      if (cap[te + 2 + j][6:2] !== exp_pix(j)) begin
        n_fail++;
        $display("FAIL switch_pass0 pos %0d: got %b, required %b", j, cap[te + 2 + j][6:2],
                 exp_pix(j));
      end
      n_checks++;
      if (cap[te + 458 + j][6:2] !== exp_pix(j)) begin
        n_fail++;
        $display("FAIL switch_pass1 pos %0d: got %b, required %b", j, cap[te + 458 + j][6:2],
                 exp_pix(j));
      end
    end
  endtask

  task automatic test_early_hsync();
    int te;
    int unknowns;
    wait_line(9);
    te = edge_tick[8];
    n_checks++;
    if (cap[te + 1][6:2] !== exp_pix(143)) begin
      n_fail++;
      $display("FAIL early_truncate: got %b, required %b", cap[te + 1][6:2], exp_pix(143));
    end
    for (int j = 0; j < 300; j++) begin
      n_checks++;
      if (cap[te + 2 + j][6:2] !== exp_pix(j)) begin
        n_fail++;
        $display("FAIL early_pass0 pos %0d: got %b, required %b", j, cap[te + 2 + j][6:2],
                 exp_pix(j));
      end
      n_checks++;
      if (cap[te + 302 + j][6:2] !== exp_pix(j)) begin
        n_fail++;
        $display("FAIL early_pass1 pos %0d: got %b, required %b", j, cap[te + 302 + j][6:2],
                 exp_pix(j));
      end
    end
    for (int t = te + 602; t <= edge_tick[9] + 1; t++) begin
      n_checks++;
      if (cap[t] !== 7'b1000000) begin
        n_fail++;
        $display("FAIL early_done tick %0d: got %b, required %b", t - te, cap[t], 7'b1000000);
      end
    end
    unknowns = 0;
    for (int t = edge_tick[7]; t <= edge_tick[9] + 1; t++) begin
      if ($isunknown(cap[t])) unknowns++;
    end
    n_checks++;
    if (unknowns !== 0) begin
      n_fail++;
      $display("FAIL early_no_x: got %0d unknown samples, required %0d", unknowns, 0);
    end
  endtask

  task automatic test_vsync();
    int highs;
    int m;
    logic exp;
    wait_line(21);
    highs = 0;
    for (int t = edge_tick[11] + 1; t <= edge_tick[20]; t++) begin
      m = 11;
      for (int k = 11; k <= 20; k++) begin
        if (edge_tick[k] < t) m = k;
      end
      exp = vs_plan[m];
      n_checks++;
      if (cap[t][0] !== exp) begin
        n_fail++;
        $display("FAIL vsync tick %0d: got %b, required %b", t, cap[t][0], exp);
      end
      if (cap[t][0] === 1'b1) highs++;
    end
    n_checks++;
    if (highs !== 192) begin
      n_fail++;
      $display("FAIL vsync_ticks: got %0d, required %0d", highs, 192);
    end
  endtask

  task automatic test_reset_mid();
    int rst_tick;
    int te;
    int budget;
    logic [4:0] exp1;
    wait_line(22);
    budget = 2000;
    while (pix < 100 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    #1 reset_n = 1'b0;
`ifdef SCANLINES_EN
    scanlines = 1'b1;
`endif
    rst_tick = tick;
    #1;
    n_checks++;
    if ({r, g, b, i, hsync, vsync, blank} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL mid_reset_values: got %b, required %b", {r, g, b, i, hsync, vsync, blank},
               7'b0000001);
    end
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;
    wait_line(25);
    te = edge_tick[24];
    for (int t = rst_tick; t <= te + 1; t++) begin
      n_checks++;
      if (cap[t] !== 7'b1000000) begin
        n_fail++;
        $display("FAIL mid_reset_idle tick %0d: got %b, required %b", t - rst_tick, cap[t],
                 7'b1000000);
      end
    end
    for (int j = 0; j < 448; j++) begin
      exp1 = exp_pix(j);
`ifdef SCANLINES_EN
      exp1[3:0] = 4'b0000;
`endif
      n_checks++;
      if (cap[te + 2 + j][6:2] !== exp_pix(j)) begin
        n_fail++;
        $display("FAIL mid_reset_pass0 pos %0d: got %b, required %b", j, cap[te + 2 + j][6:2],
                 exp_pix(j));
      end
      n_checks++;
      if (cap[te + 450 + j][6:2] !== exp1) begin
        n_fail++;
        $display("FAIL mid_reset_pass1 pos %0d: got %b, required %b", j, cap[te + 450 + j][6:2],
                 exp1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      len_plan[k]  = 448;
      vs_plan[k]   = 1'b0;
      edge_tick[k] = 0;
    end
    len_plan[5] = 456;
    len_plan[6] = 456;
    len_plan[7] = 300;
    for (int k = 10; k <= 20; k++) len_plan[k] = 24;
    for (int k = 13; k <= 16; k++) vs_plan[k] = 1'b1;

    test_reset();
    test_line_repeat();
    test_hsync();
    test_len_switch();
    test_early_hsync();
    test_vsync();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
